// File: rtl/solidsquare_y.sv
// solidsquare_y: Y-axis deflection PWM for the solid-square test pattern.
// A free-running carrier counter is compared against a level that ramps up
// and down by STEP once per frame; after RC filtering the PWM stream becomes
// a triangle wave that sweeps the beam vertically to fill the square.
`timescale 1ns/1ps

module solidsquare_y #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic sysclk,
    input  logic reset,
    input  logic Enable_SW_3,
    output logic Pulse
);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam logic [PWM_BITS-1:0] CNT_MAX     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   LEVEL_MAX_X = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0]   STEP_X      = (PWM_BITS + 1)'(STEP);

    logic                sync_ff;
    logic                en_s;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] level;
    dir_t                dir;

    logic [PWM_BITS:0]   level_sum;
    logic [PWM_BITS-1:0] level_next;
    dir_t                dir_next;

    // Two-flop synchroniser: the only place the raw switch is sampled.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_ff <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            sync_ff <= Enable_SW_3;
            en_s    <= sync_ff;
        end
    end

    // Next level/direction at end of frame, using one extra bit so the ramp saturates instead of wrapping.
    always_comb begin
        level_sum  = {1'b0, level} + STEP_X;
        level_next = level;
        dir_next   = dir;
        if (dir == DIR_UP) begin
            if (level_sum >= LEVEL_MAX_X) begin
                level_next = CNT_MAX;
                dir_next   = DIR_DOWN;
            end else begin
                level_next = level_sum[PWM_BITS-1:0];
            end
        end else begin
            if ({1'b0, level} <= STEP_X) begin
                level_next = '0;
                dir_next   = DIR_UP;
            end else begin
                level_next = level - STEP_X[PWM_BITS-1:0];
            end
        end
    end

    // Carrier, level ramp and registered PWM compare; disabling restarts the ramp from zero, rising.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= '0;
            dir   <= DIR_UP;
            Pulse <= 1'b0;
        end else if (!en_s) begin
            cnt   <= '0;
            level <= '0;
            dir   <= DIR_UP;
            Pulse <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            Pulse <= (cnt < level);
            if (cnt == CNT_MAX) begin
                level <= level_next;
                dir   <= dir_next;
            end
        end
    end

endmodule

// File: tb/tb_solidsquare_y.sv
// Testbench for solidsquare_y: per-frame high-time tables for several
// parameter sets, directed disable/reset corner cases, and a randomized
// enable pattern checked cycle by cycle against a frame-level model.
`timescale 1ns/1ps

module tb_solidsquare_y;

    typedef struct {
        int frame;
        int high;
    } frame_vec_t;

    logic sysclk = 1'b0;
    logic reset;
    logic sw;
    logic pulse_def;
    logic pulse_s100;
    logic pulse_p4;

    int tests_run    = 0;
    int tests_failed = 0;
    int frame_high[64];

    frame_vec_t vec_def[4];
    frame_vec_t vec_s100[8];
    frame_vec_t vec_p4[34];

    // 50 MHz system clock.
    always #10 sysclk = ~sysclk;

    solidsquare_y dut_def (
        .sysclk      (sysclk),
        .reset       (reset),
        .Enable_SW_3 (sw),
        .Pulse       (pulse_def)
    );

    solidsquare_y #(.PWM_BITS(8), .STEP(100)) dut_s100 (
        .sysclk      (sysclk),
        .reset       (reset),
        .Enable_SW_3 (sw),
        .Pulse       (pulse_s100)
    );

    solidsquare_y #(.PWM_BITS(4), .STEP(1)) dut_p4 (
        .sysclk      (sysclk),
        .reset       (reset),
        .Enable_SW_3 (sw),
        .Pulse       (pulse_p4)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en);
        @(negedge sysclk);
        sw = en;
    endtask

    function automatic logic pulse_of(input int sel);
        case (sel)
            0:       return pulse_def;
            1:       return pulse_s100;
            default: return pulse_p4;
        endcase
    endfunction

    // Triangle level for PWM_BITS=4, STEP=1: 0..15..1 repeating every 30 frames.
    function automatic int tri_p4(input int frame);
        int m;
        m = frame % 30;
        return (m <= 15) ? m : 30 - m;
    endfunction

    // Raise the switch; returns at the edge just before the first enabled clock.
    task automatic start_enable();
        applyStimulus(1'b1);
        repeat (2) @(posedge sysclk);
    endtask

    task automatic go_off();
        applyStimulus(1'b0);
        repeat (4) @(posedge sysclk);
    endtask

    task automatic count_frames(input int sel, input int frame_len, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            frame_high[f] = 0;
            for (int c = 0; c < frame_len; c++) begin
                @(posedge sysclk);
                #1;
                frame_high[f] += int'(pulse_of(sel));
            end
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bad;
        int hist0;
        int hist1;
        int n;
        int expv;
        int remaining;
        logic cur;

        for (int i = 0; i < 4; i++) vec_def[i] = '{i, i};
        vec_s100 = '{'{0, 0}, '{1, 100}, '{2, 200}, '{3, 255},
                     '{4, 155}, '{5, 55}, '{6, 0}, '{7, 100}};
        for (int i = 0; i < 34; i++) vec_p4[i] = '{i, tri_p4(i)};

        // Reset with the switch already on.
        sw    = 1'b1;
        reset = 1'b1;
        #100;
        checkOutput("reset pulse default", 32'(pulse_def), 0);
        checkOutput("reset pulse step100", 32'(pulse_s100), 0);
        checkOutput("reset pulse pwm4", 32'(pulse_p4), 0);
        @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(posedge sysclk);
        count_frames(0, 256, 3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("after reset frame %0d high", vec_def[i].frame),
                        32'(frame_high[vec_def[i].frame]), 32'(vec_def[i].high));

        // STEP=100 level sequence.
        go_off();
        start_enable();
        count_frames(1, 256, 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("step100 frame %0d high", vec_s100[i].frame),
                        32'(frame_high[vec_s100[i].frame]), 32'(vec_s100[i].high));

        // Full triangle with a 4-bit carrier, including peak and zero frames.
        go_off();
        start_enable();
        count_frames(2, 16, 34);
        for (int i = 0; i < 34; i++)
            checkOutput($sformatf("pwm4 frame %0d high", vec_p4[i].frame),
                        32'(frame_high[vec_p4[i].frame]), 32'(vec_p4[i].high));

        // Asynchronous reset in the middle of a high stretch.
        go_off();
        start_enable();
        repeat (8 * 16 + 3) @(posedge sysclk);
        #1;
        checkOutput("pwm4 high before async reset", 32'(pulse_p4), 1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("pwm4 low right after async reset", 32'(pulse_p4), 0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(posedge sysclk);
        count_frames(2, 16, 3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("pwm4 post-reset frame %0d high", i), 32'(frame_high[i]), 32'(i));

        // Disable latency, held-off output, then restart from level 0.
        go_off();
        start_enable();
        repeat (3 * 256) @(posedge sysclk);
        applyStimulus(1'b0);
        @(posedge sysclk);
        #1;
        checkOutput("disable edge 1 still running", 32'(pulse_def), 1);
        @(posedge sysclk);
        #1;
        checkOutput("disable edge 2 still running", 32'(pulse_def), 1);
        @(posedge sysclk);
        #1;
        checkOutput("disable edge 3 forced low", 32'(pulse_def), 0);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge sysclk);
            #1;
            if (pulse_def !== 1'b0) bad++;
        end
        checkOutput("disabled high samples", 32'(bad), 0);
        start_enable();
        count_frames(0, 256, 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("re-enable frame %0d high", vec_def[i].frame),
                        32'(frame_high[vec_def[i].frame]), 32'(vec_def[i].high));

        // Random enable pattern against a model based on enabled-clock count.
        go_off();
        hist0     = 0;
        hist1     = 0;
        n         = 0;
        remaining = 0;
        cur       = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (remaining == 0) begin
                cur       = ~cur;
                remaining = cur ? int'($urandom_range(1, 700)) : int'($urandom_range(1, 30));
            end
            applyStimulus(cur);
            remaining--;
            @(posedge sysclk);
            if (hist1 != 0) begin
                n++;
                expv = (((n - 1) % 16) < tri_p4((n - 1) / 16)) ? 1 : 0;
            end else begin
                n    = 0;
                expv = 0;
            end
            hist1 = hist0;
            hist0 = int'(sw);
            #1;
            checkOutput("random pwm4 pulse", 32'(pulse_p4), 32'(expv));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
